pcpi_initiator: RTL and testbench

- PCPI requester (core-side end) for the coprocessor interface used by the divider and multiplier wrappers.
- Accepts one instruction/operand command on a valid/ready channel, drives pcpi_valid/insn/rs1/rs2 and holds them stable until the coprocessor responds or times out.
- Returns rd, write flag and status on a response channel.
- Used as a bus-side harness to exercise and characterise exact and approximate PCPI units independently of the CPU.

---
 rtl/pcpi_initiator_if.sv | 49 ++++
 rtl/pcpi_initiator.sv | 160 ++++++++++++++++
 tb/tb_pcpi_initiator.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pcpi_initiator_if.sv
// pcpi_initiator_if
//   Groups the three channels seen by the PCPI requester:
//     command  : cmd_valid/cmd_ready/cmd_insn/cmd_rs1/cmd_rs2
//     PCPI bus : pcpi_valid/pcpi_insn/pcpi_rs1/pcpi_rs2 out,
//                pcpi_wr/pcpi_rd/pcpi_wait/pcpi_ready back
//     response : rsp_valid/rsp_ready/rsp_rd/rsp_wr/rsp_status/rsp_cycles
//   master : the requester (pcpi_initiator) view
//   slave  : the environment view (command source, coprocessor, response sink)
interface pcpi_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_insn;
  logic [31:0] cmd_rs1;
  logic [31:0] cmd_rs2;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd;
  logic        rsp_wr;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_cycles;

  modport master (
    input  cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  rsp_ready,
    output cmd_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output rsp_valid, rsp_rd, rsp_wr, rsp_status, rsp_cycles
  );

  modport slave (
    output cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output rsp_ready,
    input  cmd_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  rsp_valid, rsp_rd, rsp_wr, rsp_status, rsp_cycles
  );
endinterface

// File: rtl/pcpi_initiator.sv
// pcpi_initiator
//   Core-side PCPI requester. Takes one command (insn/rs1/rs2) on a
//   valid/ready channel, presents it to a coprocessor on the PCPI bus and
//   holds it stable until pcpi_ready or a timeout, then returns rd, the
//   write flag and a status on a response channel.
//   Ports:
//     clk    : clock, rising edge
//     resetn : asynchronous active-low reset
//     bus    : pcpi_initiator_if.master (command, PCPI and response channels)
//   rsp_status: 00 ok+write, 01 ok no-write, 10 timeout (11 never driven).
//   Optional build macro PCPI_INIT_CYCLE_COUNT_EN: when defined, rsp_cycles
//   reports how many cycles pcpi_valid was high; otherwise it is tied to 0.
module pcpi_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic            clk,
  input  logic            resetn,
  pcpi_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, next_state;
  logic [CNT_W-1:0] to_cnt, to_cnt_next;
  logic             accept;
  logic             capture_ok;
  logic             capture_to;

  logic [31:0]      insn_q, rs1_q, rs2_q;
  logic [31:0]      rd_q;
  logic             wr_q;
  logic [1:0]       status_q;

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      to_cnt <= TO_LOAD;
    end else begin
      state  <= next_state;
      to_cnt <= to_cnt_next;
    end
  end

  // Next-state logic. pcpi_ready is tested before the timeout so a response
  // landing on the terminal count still completes normally. pcpi_wait only
  // rearms the timeout; it never ends the request.
  always_comb begin
    next_state  = state;
    to_cnt_next = to_cnt;
    accept      = 1'b0;
    capture_ok  = 1'b0;
    capture_to  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept      = 1'b1;
          to_cnt_next = TO_LOAD;
          next_state  = BUSY;
        end
      end
      BUSY: begin
        if (bus.pcpi_ready) begin
          capture_ok = 1'b1;
          next_state = RESP;
        end else if (bus.pcpi_wait) begin
          to_cnt_next = TO_LOAD;
        end else if (to_cnt == CNT_W'(1)) begin
          capture_to = 1'b1;
          next_state = RESP;
        end else begin
          to_cnt_next = to_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Command and response datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      insn_q   <= 32'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      rd_q     <= 32'd0;
      wr_q     <= 1'b0;
      status_q <= 2'b00;
    end else begin
      if (accept) begin
        insn_q <= bus.cmd_insn;
        rs1_q  <= bus.cmd_rs1;
        rs2_q  <= bus.cmd_rs2;
      end
      if (capture_ok) begin
        rd_q     <= bus.pcpi_rd;
        wr_q     <= bus.pcpi_wr;
        status_q <= bus.pcpi_wr ? 2'b00 : 2'b01;
      end else if (capture_to) begin
        rd_q     <= 32'd0;
        wr_q     <= 1'b0;
        status_q <= 2'b10;
      end
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.pcpi_valid = (state == BUSY);
  assign bus.pcpi_insn  = insn_q;
  assign bus.pcpi_rs1   = rs1_q;
  assign bus.pcpi_rs2   = rs2_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_rd     = rd_q;
  assign bus.rsp_wr     = wr_q;
  assign bus.rsp_status = status_q;

`ifdef PCPI_INIT_CYCLE_COUNT_EN
  logic [15:0] cyc_cnt;
  logic [15:0] cyc_inc;
  logic [15:0] cyc_q;

  // The latched value includes the BUSY cycle in which the request ends, so
  // it equals the number of cycles pcpi_valid was high.
  assign cyc_inc = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc_cnt <= 16'd0;
      cyc_q   <= 16'd0;
    end else begin
      if (accept) begin
        cyc_cnt <= 16'd0;
      end else if (state == BUSY) begin
        cyc_cnt <= cyc_inc;
      end
      if (capture_ok || capture_to) begin
        cyc_q <= cyc_inc;
      end
    end
  end

  assign bus.rsp_cycles = cyc_q;
`else
  assign bus.rsp_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pcpi_initiator.sv
// tb_pcpi_initiator
//   Directed bench for pcpi_initiator: reset values, normal completion,
//   timeout, keep-alive, response backpressure, ready-vs-timeout priority
//   and reset in the middle of a request.
module tb_pcpi_initiator;

  localparam int TIMEOUT = 16;
`ifdef PCPI_INIT_CYCLE_COUNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  pcpi_initiator_if bus ();

  pcpi_initiator #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cycles(input int n);
    return CYC_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic send_cmd(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.cmd_valid = 1'b1;
    bus.cmd_insn  = insn;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int  cnt;
    int  bad;
    checks = 0;
    errors = 0;

    resetn         = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_insn   = 32'd0;
    bus.cmd_rs1    = 32'd0;
    bus.cmd_rs2    = 32'd0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'd0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.rsp_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    check_output("rst_cmd_ready",  32'(bus.cmd_ready),  32'd1);
    check_output("rst_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    check_output("rst_pcpi_insn",  bus.pcpi_insn,       32'd0);
    check_output("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check_output("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
    check_output("rst_rsp_cycles", 32'(bus.rsp_cycles), 32'd0);
    resetn = 1'b1;
    tick();

    // Normal completion: wait from cycle 1, ready+wr on cycle 5
    $display("[TB] normal completion");
    bus.pcpi_wait = 1'b1;
    send_cmd(32'h02C5C533, 32'd100, 32'd7);
    check_output("norm_pcpi_valid", 32'(bus.pcpi_valid), 32'd1);
    check_output("norm_cmd_ready",  32'(bus.cmd_ready),  32'd0);
    check_output("norm_insn",       bus.pcpi_insn,       32'h02C5C533);
    check_output("norm_rs1",        bus.pcpi_rs1,        32'd100);
    check_output("norm_rs2",        bus.pcpi_rs2,        32'd7);
    repeat (4) tick();
    check_output("norm_valid_c5", 32'(bus.pcpi_valid), 32'd1);
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'd14;
    tick();
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'd0;
    check_output("norm_pcpi_valid_low", 32'(bus.pcpi_valid), 32'd0);
    check_output("norm_rsp_valid",      32'(bus.rsp_valid),  32'd1);
    check_output("norm_rsp_rd",         bus.rsp_rd,          32'd14);
    check_output("norm_rsp_wr",         32'(bus.rsp_wr),     32'd1);
    check_output("norm_rsp_status",     32'(bus.rsp_status), 32'd0);
    check_output("norm_rsp_cycles",     32'(bus.rsp_cycles), exp_cycles(5));
    drain_rsp();
    check_output("norm_rsp_valid_clr", 32'(bus.rsp_valid), 32'd0);
    check_output("norm_cmd_ready_ret", 32'(bus.cmd_ready), 32'd1);

    // Timeout: silent responder
    $display("[TB] timeout");
    send_cmd(32'h0000_1111, 32'd1, 32'd2);
    cnt = 0;
    for (int i = 0; i < 40 && !bus.rsp_valid; i++) begin
      if (bus.pcpi_valid) cnt++;
      tick();
    end
    check_output("to_valid_cycles", 32'(cnt),            32'(TIMEOUT));
    check_output("to_rsp_valid",    32'(bus.rsp_valid),  32'd1);
    check_output("to_rsp_status",   32'(bus.rsp_status), 32'd2);
    check_output("to_rsp_rd",       bus.rsp_rd,          32'd0);
    check_output("to_rsp_wr",       32'(bus.rsp_wr),     32'd0);
    check_output("to_rsp_cycles",   32'(bus.rsp_cycles), exp_cycles(TIMEOUT));
    drain_rsp();

    // Keep-alive: wait for 40 cycles, then ready without write
    $display("[TB] keep-alive");
    bus.pcpi_wait = 1'b1;
    send_cmd(32'h02C5D533, 32'd9, 32'd3);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.pcpi_valid || bus.rsp_valid) bad++;
      tick();
    end
    check_output("ka_no_timeout", 32'(bad), 32'd0);
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'hDEADBEEF;
    tick();
    bus.pcpi_ready = 1'b0;
    check_output("ka_rsp_status", 32'(bus.rsp_status), 32'd1);
    check_output("ka_rsp_wr",     32'(bus.rsp_wr),     32'd0);
    check_output("ka_rsp_rd",     bus.rsp_rd,          32'hDEADBEEF);
    check_output("ka_rsp_cycles", 32'(bus.rsp_cycles), exp_cycles(41));

    // Backpressure: hold the response 5 cycles with a second command pending
    $display("[TB] backpressure");
    bus.cmd_valid = 1'b1;
    bus.cmd_insn  = 32'h11111111;
    bus.cmd_rs1   = 32'h22222222;
    bus.cmd_rs2   = 32'h33333333;
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'h0BAD0BAD;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.rsp_valid || bus.cmd_ready || bus.pcpi_valid) bad++;
      if (bus.rsp_rd !== 32'hDEADBEEF || bus.rsp_status !== 2'b01 || bus.rsp_wr !== 1'b0) bad++;
      if (bus.pcpi_insn !== 32'h02C5D533) bad++;
    end
    check_output("bp_hold_stable", 32'(bad), 32'd0);
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    drain_rsp();
    check_output("bp_cmd_ready_idle", 32'(bus.cmd_ready),  32'd1);
    check_output("bp_no_pcpi_valid",  32'(bus.pcpi_valid), 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    check_output("bp_second_valid", 32'(bus.pcpi_valid), 32'd1);
    check_output("bp_second_insn",  bus.pcpi_insn,       32'h11111111);
    check_output("bp_second_rs2",   bus.pcpi_rs2,        32'h33333333);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'd5;
    tick();
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    check_output("bp_second_rd",     bus.rsp_rd,          32'd5);
    check_output("bp_second_cycles", 32'(bus.rsp_cycles), exp_cycles(1));
    drain_rsp();

    // Priority: ready on the terminal-count cycle wins over timeout
    $display("[TB] priority");
    send_cmd(32'hABCD0001, 32'd4, 32'd4);
    repeat (TIMEOUT - 1) tick();
    check_output("prio_still_busy", 32'(bus.pcpi_valid), 32'd1);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'd7;
    tick();
    bus.pcpi_ready = 1'b0;
    check_output("prio_rsp_valid",  32'(bus.rsp_valid),  32'd1);
    check_output("prio_rsp_status", 32'(bus.rsp_status), 32'd1);
    check_output("prio_rsp_rd",     bus.rsp_rd,          32'd7);
    check_output("prio_rsp_cycles", 32'(bus.rsp_cycles), exp_cycles(TIMEOUT));
    drain_rsp();

    // Reset in the middle of a request
    $display("[TB] reset mid-busy");
    bus.pcpi_wait = 1'b1;
    send_cmd(32'h55AA55AA, 32'd1, 32'd1);
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check_output("rstb_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    check_output("rstb_pcpi_insn",  bus.pcpi_insn,       32'd0);
    tick();
    tick();
    check_output("rstb_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    resetn = 1'b1;
    bus.pcpi_wait = 1'b0;
    tick();
    check_output("rstb_cmd_ready",   32'(bus.cmd_ready),  32'd1);
    check_output("rstb_rsp_valid2",  32'(bus.rsp_valid),  32'd0);
    check_output("rstb_pcpi_valid2", 32'(bus.pcpi_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
